// File: rtl/pause_ctrl.sv
// Core pause controller: merges user toggle, OSD and external pause requests,
// optionally aligns soft pauses to vblank, and dims video after a long user pause.
module pause_ctrl #(
  parameter int          NUM_REQ     = 1,
  parameter int unsigned DIM_TIMEOUT = 32'h0ABA9500,
  parameter int          DIM_SHIFT   = 1,
  parameter int          R_W         = 3,
  parameter int          G_W         = 3,
  parameter int          B_W         = 2,
  parameter bit          SYNC_VBL    = 1'b1
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     user_pause,
  input  logic                     osd_open,
  input  logic                     osd_pause_en,
  input  logic [NUM_REQ-1:0]       req,
  input  logic                     vblank,
  input  logic [R_W+G_W+B_W-1:0]   rgb_in,
  output logic [R_W+G_W+B_W-1:0]   rgb_out,
  output logic                     pause,
  output logic                     paused_user,
  output logic                     dim_active
);

  localparam int RGB_W = R_W + G_W + B_W;
  localparam int CNT_W = (DIM_TIMEOUT == 0) ? 1 : $clog2(64'(DIM_TIMEOUT) + 64'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIM_TIMEOUT);

  logic             user_q, user_d;
  logic             armed_q, armed_d;
  logic             vblank_q, vblank_d;
  logic             paused_user_q, paused_user_d;
  logic             soft_latched_q, soft_latched_d;
  logic             pause_q, pause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dim_active_q, dim_active_d;
  logic [RGB_W-1:0] rgb_out_q, rgb_out_d;

  logic             user_rise, vbl_rise, soft_req, hard_req;
  logic [R_W-1:0]   r_in;
  logic [G_W-1:0]   g_in;
  logic [B_W-1:0]   b_in;

  always_comb begin
    // armed_q blocks a button already held through reset from toggling on release
    user_rise      = user_pause & ~user_q & armed_q;
    user_d         = user_pause;
    armed_d        = armed_q | ~user_pause;
    paused_user_d  = paused_user_q ^ user_rise;

    vbl_rise       = vblank & ~vblank_q;
    vblank_d       = vblank;
    hard_req       = |req;
    soft_req       = paused_user_q | (osd_open & osd_pause_en);

    if (SYNC_VBL) soft_latched_d = soft_req & (soft_latched_q | vbl_rise);
    else          soft_latched_d = soft_req;
    pause_d        = hard_req | soft_latched_d;

    cnt_d = '0;
    if (paused_user_q) cnt_d = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    dim_active_d   = (DIM_TIMEOUT != 0) && paused_user_d && (cnt_d == CNT_MAX);

    r_in = rgb_in[RGB_W-1 -: R_W];
    g_in = rgb_in[B_W +: G_W];
    b_in = rgb_in[B_W-1:0];
    if (dim_active_d) rgb_out_d = {r_in >> DIM_SHIFT, g_in >> DIM_SHIFT, b_in >> DIM_SHIFT};
    else              rgb_out_d = rgb_in;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      user_q         <= 1'b0;
      armed_q        <= 1'b0;
      vblank_q       <= 1'b0;
      paused_user_q  <= 1'b0;
      soft_latched_q <= 1'b0;
      pause_q        <= 1'b0;
      cnt_q          <= '0;
      dim_active_q   <= 1'b0;
      rgb_out_q      <= '0;
    end else begin
      user_q         <= user_d;
      armed_q        <= armed_d;
      vblank_q       <= vblank_d;
      paused_user_q  <= paused_user_d;
      soft_latched_q <= soft_latched_d;
      pause_q        <= pause_d;
      cnt_q          <= cnt_d;
      dim_active_q   <= dim_active_d;
      rgb_out_q      <= rgb_out_d;
    end
  end

  assign rgb_out     = rgb_out_q;
  assign pause       = pause_q;
  assign paused_user = paused_user_q;
  assign dim_active  = dim_active_q;

endmodule

// File: tb/tb_pause_ctrl.sv
// Self-checking bench: two pause_ctrl configurations driven from shared inputs
// and compared against a cycle-level behavioural model of the pause rules.
module tb_pause_ctrl;

  logic       clk = 1'b0;
  logic       reset, user_pause, osd_open, osd_pause_en, vblank;
  logic [1:0] req;
  logic [7:0] rgb_in;
  logic [7:0] o_rgb [2];
  logic       o_pause [2], o_puser [2], o_dim [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // dut 0: vblank-synced, dims after 16 cycles; dut 1: immediate, dimming disabled
  pause_ctrl #(.NUM_REQ(2), .DIM_TIMEOUT(16), .DIM_SHIFT(1), .SYNC_VBL(1'b1)) u_a (
    .clk_sys(clk), .reset(reset), .user_pause(user_pause), .osd_open(osd_open),
    .osd_pause_en(osd_pause_en), .req(req), .vblank(vblank), .rgb_in(rgb_in),
    .rgb_out(o_rgb[0]), .pause(o_pause[0]), .paused_user(o_puser[0]), .dim_active(o_dim[0]));

  pause_ctrl #(.NUM_REQ(2), .DIM_TIMEOUT(0), .DIM_SHIFT(2), .SYNC_VBL(1'b0)) u_b (
    .clk_sys(clk), .reset(reset), .user_pause(user_pause), .osd_open(osd_open),
    .osd_pause_en(osd_pause_en), .req(req), .vblank(vblank), .rgb_in(rgb_in),
    .rgb_out(o_rgb[1]), .pause(o_pause[1]), .paused_user(o_puser[1]), .dim_active(o_dim[1]));

  function automatic int cfg_timeout(int i); return (i == 0) ? 16 : 0; endfunction
  function automatic int cfg_shift(int i);   return (i == 0) ? 1 : 2;  endfunction
  function automatic bit cfg_sync(int i);    return (i == 0);          endfunction

  function automatic logic [7:0] dimmed(logic [7:0] v, int sh);
    logic [2:0] r, g;
    logic [1:0] b;
    r = v[7:5]; g = v[4:2]; b = v[1:0];
    r = r >> sh; g = g >> sh; b = b >> sh;
    return {r, g, b};
  endfunction

  // behavioural model state
  bit         m_prev_u [2], m_seen_low [2], m_paused [2], m_prev_v [2], m_latched [2];
  bit         m_pause [2], m_dim [2];
  int         m_held [2];
  logic [7:0] m_rgb [2];
  bit         t_rise, t_soft, t_old;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_prev_u[i] = 0; m_seen_low[i] = 0; m_paused[i] = 0; m_prev_v[i] = 0;
        m_latched[i] = 0; m_pause[i] = 0; m_dim[i] = 0; m_held[i] = 0; m_rgb[i] = 8'h00;
      end else begin
        t_old  = m_paused[i];
        t_rise = user_pause && !m_prev_u[i] && m_seen_low[i];
        if (t_rise) m_paused[i] = !m_paused[i];
        if (!user_pause) m_seen_low[i] = 1;
        m_prev_u[i] = user_pause;
        t_soft = t_old || (osd_open && osd_pause_en);
        if (!cfg_sync(i))      m_latched[i] = t_soft;
        else if (!t_soft)      m_latched[i] = 0;
        else if (vblank && !m_prev_v[i]) m_latched[i] = 1;
        m_prev_v[i] = vblank;
        m_pause[i] = (req != 2'b00) || m_latched[i];
        if (!m_paused[i] || !t_old) m_held[i] = 0;
        else m_held[i] = m_held[i] + 1;
        m_dim[i] = (cfg_timeout(i) != 0) && m_paused[i] && (m_held[i] >= cfg_timeout(i));
        m_rgb[i] = m_dim[i] ? dimmed(rgb_in, cfg_shift(i)) : rgb_in;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; user_pause = 0; osd_open = 0; osd_pause_en = 0; req = 0; vblank = 0; rgb_in = 0;
    step(); step();
    reset = 0;
    step(); step();
  endtask

  task automatic test_reset();
    reset = 1; user_pause = 1; osd_open = 1; osd_pause_en = 1; req = 2'b11; vblank = 1; rgb_in = 8'hFF;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({o_pause[i], o_puser[i], o_dim[i], o_rgb[i]} !== 11'd0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got %0h want 0", i, {o_pause[i], o_puser[i], o_dim[i], o_rgb[i]});
      end
    end
  endtask

  task automatic test_vbl_sync();
    bit seen = 0;
    do_reset();
    user_pause = 1; step(); user_pause = 0;
    n_cmp++;
    if (o_puser[0] !== 1'b1 || o_pause[0] !== 1'b0) begin
      n_err++; $display("FAIL vbl_toggle: got puser=%b pause=%b want 1 0", o_puser[0], o_pause[0]);
    end
    for (int k = 0; k < 40; k++) begin step(); if (o_pause[0] !== 1'b0) seen = 1; end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL vbl_wait: got pause=1 before vblank want 0"); end
    vblank = 1; step(); vblank = 0;
    n_cmp++;
    if (o_pause[0] !== 1'b1) begin n_err++; $display("FAIL vbl_edge: got pause=%b want 1", o_pause[0]); end
    step();
    user_pause = 1; step(); user_pause = 0;
    n_cmp++;
    if (o_puser[0] !== 1'b0 || o_pause[0] !== 1'b1) begin
      n_err++; $display("FAIL vbl_unpause1: got puser=%b pause=%b want 0 1", o_puser[0], o_pause[0]);
    end
    step();
    n_cmp++;
    if (o_pause[0] !== 1'b0) begin n_err++; $display("FAIL vbl_unpause2: got pause=%b want 0", o_pause[0]); end
  endtask

  task automatic test_hard_req();
    do_reset();
    req = 2'b10;
    for (int k = 0; k < 5; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (o_pause[i] !== 1'b1 || o_dim[i] !== 1'b0) begin
          n_err++; $display("FAIL hard_req_on dut%0d cyc%0d: got pause=%b dim=%b want 1 0", i, k, o_pause[i], o_dim[i]);
        end
      end
    end
    req = 2'b00; step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (o_pause[i] !== 1'b0) begin n_err++; $display("FAIL hard_req_off dut%0d: got %b want 0", i, o_pause[i]); end
    end
  endtask

  task automatic test_dim();
    bit         exp_dim;
    logic [7:0] exp_rgb;
    do_reset();
    rgb_in = 8'b110_101_11;
    user_pause = 1; step(); user_pause = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_dim = (k >= 16);
      exp_rgb = exp_dim ? 8'b011_010_01 : 8'b110_101_11;
      n_cmp++;
      if (o_dim[0] !== exp_dim || o_rgb[0] !== exp_rgb) begin
        n_err++; $display("FAIL dim k=%0d: got dim=%b rgb=%h want %b %h", k, o_dim[0], o_rgb[0], exp_dim, exp_rgb);
      end
    end
    user_pause = 1; step(); user_pause = 0;
    n_cmp++;
    if (o_dim[0] !== 1'b0 || o_rgb[0] !== 8'b110_101_11) begin
      n_err++; $display("FAIL dim_release: got dim=%b rgb=%h want 0 d7", o_dim[0], o_rgb[0]);
    end
  endtask

  task automatic test_osd();
    do_reset();
    osd_open = 1; osd_pause_en = 0; step(); step(); step();
    n_cmp++;
    if (o_pause[0] !== 1'b0) begin n_err++; $display("FAIL osd_disabled: got %b want 0", o_pause[0]); end
    osd_pause_en = 1; step(); step();
    n_cmp++;
    if (o_pause[0] !== 1'b0) begin n_err++; $display("FAIL osd_no_vbl: got %b want 0", o_pause[0]); end
    vblank = 1; step(); vblank = 0; step();
    n_cmp++;
    if (o_pause[0] !== 1'b1 || o_dim[0] !== 1'b0) begin
      n_err++; $display("FAIL osd_vbl: got pause=%b dim=%b want 1 0", o_pause[0], o_dim[0]);
    end
    osd_open = 0; step();
    n_cmp++;
    if (o_pause[0] !== 1'b0) begin n_err++; $display("FAIL osd_close: got %b want 0", o_pause[0]); end
  endtask

  task automatic test_reset_mid_dim();
    do_reset();
    rgb_in = 8'hD7; user_pause = 1;
    for (int k = 0; k < 20; k++) step();
    n_cmp++;
    if (o_dim[0] !== 1'b1) begin n_err++; $display("FAIL rst_dim_pre: got %b want 1", o_dim[0]); end
    reset = 1; step(); reset = 0;
    n_cmp++;
    if ({o_pause[0], o_puser[0], o_dim[0], o_rgb[0]} !== 11'd0) begin
      n_err++; $display("FAIL rst_dim_clear: got %h want 0", {o_pause[0], o_puser[0], o_dim[0], o_rgb[0]});
    end
    for (int k = 0; k < 5; k++) step();
    n_cmp++;
    if (o_puser[0] !== 1'b0) begin n_err++; $display("FAIL rst_held_btn: got %b want 0", o_puser[0]); end
    user_pause = 0; step(); user_pause = 1; step();
    n_cmp++;
    if (o_puser[0] !== 1'b1) begin n_err++; $display("FAIL rst_repress: got %b want 1", o_puser[0]); end
    user_pause = 0;
  endtask

  task automatic test_no_dim();
    logic [7:0] v;
    do_reset();
    user_pause = 1;
    for (int k = 0; k < 1000; k++) begin
      v = 8'($urandom); rgb_in = v; step();
      n_cmp++;
      if (o_dim[1] !== 1'b0 || o_rgb[1] !== v) begin
        n_err++; $display("FAIL no_dim k=%0d: got dim=%b rgb=%h want 0 %h", k, o_dim[1], o_rgb[1], v);
      end
    end
    n_cmp++;
    if (o_puser[1] !== 1'b1) begin n_err++; $display("FAIL no_dim_puser: got %b want 1", o_puser[1]); end
    user_pause = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) user_pause = ~user_pause;
      if ($urandom_range(0, 19) == 0) vblank = ~vblank;
      if ($urandom_range(0, 59) == 0) osd_open = ~osd_open;
      if ($urandom_range(0, 89) == 0) osd_pause_en = ~osd_pause_en;
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 39) == 0) req[b] = ~req[b];
      rgb_in = 8'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (o_pause[i] !== m_pause[i] || o_puser[i] !== m_paused[i] || o_dim[i] !== m_dim[i] || o_rgb[i] !== m_rgb[i]) begin
          n_err++;
          $display("FAIL random dut%0d k=%0d: got p=%b u=%b d=%b rgb=%h want %b %b %b %h", i, k,
                   o_pause[i], o_puser[i], o_dim[i], o_rgb[i], m_pause[i], m_paused[i], m_dim[i], m_rgb[i]);
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; user_pause = 0; osd_open = 0; osd_pause_en = 0; req = 0; vblank = 0; rgb_in = 0;
    test_reset();
    test_vbl_sync();
    test_hard_req();
    test_dim();
    test_osd();
    test_reset_mid_dim();
    test_no_dim();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pause_ctrl.md
PAUSE_CTRL -- requirements
Module: pause_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 1: number of external immediate pause requesters (e.g. hiscore RAM access); range 1..8.
REQ-002 SHALL have parameter DIM_TIMEOUT, default 32'h0ABA9500: clk_sys cycles of user pause before dimming; 0 disables dimming.
REQ-003 SHALL have parameter DIM_SHIFT, default 1: right-shift applied to each colour channel when dimmed; range 0..R_W.
REQ-004 SHALL have parameters R_W, G_W, B_W, defaults 3, 3, 2: colour channel widths.
REQ-005 SHALL have parameter SYNC_VBL, default 1: 1 = user/OSD pause assertion aligned to vblank rising edge; 0 = immediate.
REQ-006 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port user_pause  input  1  level pause button (joystick bit).
REQ-009 SHALL have port osd_open  input  1  OSD currently displayed.
REQ-010 SHALL have port osd_pause_en  input  1  1 = pause while OSD open.
REQ-011 SHALL have port req  input  NUM_REQ  external pause requests, active-high.
REQ-012 SHALL have port vblank  input  1  video vertical blank.
REQ-013 SHALL have port rgb_in  input  R_W+G_W+B_W  {r,g,b}, r in MSBs.
REQ-014 SHALL have port rgb_out  output  R_W+G_W+B_W  registered, possibly dimmed {r,g,b}.
REQ-015 SHALL have port pause  output  1  core pause, active-high, registered.
REQ-016 SHALL have port paused_user  output  1  current user toggle state.
REQ-017 SHALL have port dim_active  output  1  dimming currently applied.

Function
REQ-018 SHALL register user_pause once and toggle paused_user on each rising edge (prev 0, current 1); held level causes one toggle only.
REQ-019 SHALL form soft_req = paused_user | (osd_open & osd_pause_en), and hard_req = OR of req bits.
REQ-020 SHALL drive pause high on the cycle after hard_req goes high, regardless of SYNC_VBL or vblank.
REQ-021 With SYNC_VBL=1, SHALL set an internal soft_latched flag only on the cycle vblank rising edge is detected (registered vblank 0, current 1) while soft_req=1; with SYNC_VBL=0, soft_latched follows soft_req with one-cycle latency.
REQ-022 SHALL clear soft_latched on the cycle after soft_req falls, without waiting for vblank.
REQ-023 SHALL register pause = hard_req | soft_latched (one-cycle latency from either term).
REQ-024 SHALL keep a saturating dim counter of width $clog2(DIM_TIMEOUT+1) (min 1): increments each cycle while paused_user=1 and count<DIM_TIMEOUT; holds at DIM_TIMEOUT; loads 0 on any cycle paused_user=0.
REQ-025 SHALL assert dim_active when DIM_TIMEOUT!=0 and count==DIM_TIMEOUT; DIM_TIMEOUT=0 holds dim_active at 0.
REQ-026 SHALL not dim for OSD or hard_req pause alone.
REQ-027 SHALL register rgb_out every cycle (latency 1): each channel = channel>>DIM_SHIFT (zero-fill) when dim_active, else unchanged.
REQ-028 Counter and pause logic SHALL not wrap; counter saturation prevents overflow for any DIM_TIMEOUT up to 2^32-1.
REQ-029 On simultaneous user_pause rising edge and reset, reset SHALL win; the edge is not recorded.

Reset
REQ-030 On reset SHALL clear paused_user, soft_latched, pause, dim counter, dim_active, rgb_out, and edge-detect registers to 0.
REQ-031 Reset asserted mid-pause or mid-dim SHALL return all outputs to 0 the following cycle; after release, a user_pause already held high SHALL not toggle until it falls and rises again.

Verification
REQ-032 SYNC_VBL=1: user_pause pulse with vblank low -> pause stays 0; vblank rising 40 cycles later -> pause=1 one cycle after edge; second user_pause pulse -> pause=0 next-but-one cycle.
REQ-033 NUM_REQ=2: req=2'b10 pulse 5 cycles, vblank low -> pause=1 for exactly 5 cycles, delayed 1; dim_active stays 0.
REQ-034 DIM_TIMEOUT=16, DIM_SHIFT=1: user pause held -> dim_active=1 at 16 cycles after toggle; rgb_in={3'b110,3'b101,2'b11} -> rgb_out={3'b011,3'b010,2'b01}; unpause -> dim_active=0 and undimmed rgb_out next cycle.
REQ-035 osd_open=1, osd_pause_en=0 -> pause=0; osd_pause_en=1 -> pause=1 after next vblank edge; osd_open=0 -> pause=0 one cycle later.
REQ-036 Reset asserted at dim_active=1 with user_pause held high -> all outputs 0 next cycle; after release, no toggle until user_pause 0->1.
REQ-037 DIM_TIMEOUT=0: user pause held 1000 cycles -> dim_active=0, rgb_out equals rgb_in delayed 1.
